bram_stream_reader: RTL and testbench

Read-side controller for one port of the 256-bit dual-port local-memory BRAM. It accepts a (base address, length) read command and issues sequential single-cycle BRAM reads, absorbing the BRAM's 1-cycle read latency. It returns the words as a valid/ready stream with backpressure and a last marker. It sits between the memory BRAM and the systolic-array / DRAM-writeback datapaths that consume local-memory contents.

---
 rtl/bram_stream_reader.sv | 167 ++++++++++++++++
 tb/tb_bram_stream_reader.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_stream_reader.sv
// bram_stream_reader
// Read-side controller for one port of the 256-bit local-memory BRAM.
// Turns a (base address, length) command into back-to-back single-cycle
// reads and hands the returned words out as a valid/ready stream with a
// last marker. The BRAM's one-cycle read latency is absorbed by a 2-entry
// output FIFO. Reads are only issued when a FIFO slot is guaranteed, so
// backpressure never drops or duplicates a word.

module bram_stream_reader #(
   parameter int DATA_WIDTH = 256,
   parameter int ADDR_WIDTH = 15,
   parameter int DEPTH      = 20480,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [LEN_WIDTH-1:0]  cmd_len,
   output logic                  ram_en,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   input  logic [DATA_WIDTH-1:0] ram_dout,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic                  busy,
   output logic                  err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [31:0]           DEPTH_W   = 32'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
   localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = LEN_WIDTH'(1);

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [ADDR_WIDTH-1:0]   holdAddr_q, holdAddr_d;
   logic [LEN_WIDTH-1:0]    remain_q, remain_d;
   logic                    inflight_q, inflight_d;
   logic                    inflightLast_q, inflightLast_d;
   logic                    err_q, err_d;

   logic [DATA_WIDTH-1:0]   fifoData_q [2];
   logic [1:0]              fifoLast_q;
   logic                    wrPtr_q;
   logic                    rdPtr_q;
   logic [1:0]              count_q;

   logic                    pop;
   logic                    push;
   logic                    issue;
   logic                    addrInRange;
   logic [2:0]              occupancy;

   assign pop         = (count_q != 2'd0) && out_ready;
   assign push        = inflight_q;
   assign occupancy   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign issue       = (state_q == READ) && (occupancy < 3'd2);
   assign addrInRange = {{(32-ADDR_WIDTH){1'b0}}, cmd_addr} < DEPTH_W;

   assign cmd_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign err       = err_q;
   assign out_valid = (count_q != 2'd0);
   assign out_data  = fifoData_q[rdPtr_q];
   assign out_last  = fifoLast_q[rdPtr_q];

   // Command acceptance, read issue with address wrap, and drain detection;
   // the BRAM port is driven directly so a read goes out the cycle it is allowed.
   always_comb begin
      state_d        = state_q;
      addr_d         = addr_q;
      holdAddr_d     = holdAddr_q;
      remain_d       = remain_q;
      inflight_d     = issue;
      inflightLast_d = issue && (remain_q == '0);
      err_d          = 1'b0;
      ram_en         = issue;
      ram_addr       = issue ? addr_q : holdAddr_q;

      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               if (addrInRange) begin
                  addr_d   = cmd_addr;
                  remain_d = cmd_len;
                  state_d  = READ;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         READ: begin
            if (issue) begin
               holdAddr_d = addr_q;
               addr_d     = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_ONE;
               if (remain_q == '0) begin
                  state_d = DRAIN;
               end else begin
                  remain_d = remain_q - LEN_ONE;
               end
            end
         end
         DRAIN: begin
            if (!inflight_q && (occupancy == 3'd0)) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control state register; reset abandons any command in progress.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         addr_q         <= '0;
         holdAddr_q     <= '0;
         remain_q       <= '0;
         inflight_q     <= 1'b0;
         inflightLast_q <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         addr_q         <= addr_d;
         holdAddr_q     <= holdAddr_d;
         remain_q       <= remain_d;
         inflight_q     <= inflight_d;
         inflightLast_q <= inflightLast_d;
         err_q          <= err_d;
      end
   end

   // Two-entry output FIFO: captures the BRAM word the cycle after its read
   // and pops on an output handshake; cleared so outputs read zero after reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fifoData_q[0] <= '0;
         fifoData_q[1] <= '0;
         fifoLast_q    <= 2'b00;
         wrPtr_q       <= 1'b0;
         rdPtr_q       <= 1'b0;
         count_q       <= 2'd0;
      end else begin
         if (push) begin
            fifoData_q[wrPtr_q] <= ram_dout;
            fifoLast_q[wrPtr_q] <= inflightLast_q;
            wrPtr_q             <= ~wrPtr_q;
         end
         if (pop) begin
            rdPtr_q <= ~rdPtr_q;
         end
         count_q <= count_q + {1'b0, push} - {1'b0, pop};
      end
   end

endmodule

// File: tb/tb_bram_stream_reader.sv
// tb_bram_stream_reader
// Cycle-exact vector table for a basic read, a single-word read and a bad
// address, then scoreboard-checked sequences: backpressure, wrap-around,
// back-to-back commands, reset mid-command and random commands.

module tb_bram_stream_reader;

   localparam int DW    = 256;
   localparam int AW    = 15;
   localparam int DEPTH = 20480;
   localparam int LW    = 16;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [AW-1:0] cmd_addr = '0;
   logic [LW-1:0] cmd_len = '0;
   logic          ram_en;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ramDout = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          busy;
   logic          err;

   int errorCount = 0;
   int checkCount = 0;

   typedef struct {
      logic cmdValid;
      int   cmdAddr;
      int   cmdLen;
      logic outReady;
      logic expRamEn;
      int   expRamAddr;
      logic expOutValid;
      int   expWordAddr;
      logic expLast;
      logic expCmdReady;
      logic expBusy;
      logic expErr;
   } vec_t;

   vec_t vecs[$];

   // Scoreboard state: addresses still to be issued, words still to be
   // delivered with their last flags, and words issued but not yet taken.
   int   issueQ[$];
   int   wordQ[$];
   bit   lastQ[$];
   int   outstanding = 0;
   bit   prevStall = 1'b0;
   logic [DW-1:0] prevData = '0;
   logic prevLast = 1'b0;
   bit   errExpectNow = 1'b0;
   bit   handshakeSeen = 1'b0;
   bit   monEn = 1'b0;
   int   stretchLeft = 0;

   bram_stream_reader #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .DEPTH(DEPTH),
      .LEN_WIDTH(LW)
   ) dut (
      .clock(clock),
      .reset(reset),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_addr(cmd_addr),
      .cmd_len(cmd_len),
      .ram_en(ram_en),
      .ram_addr(ram_addr),
      .ram_dout(ramDout),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .out_last(out_last),
      .busy(busy),
      .err(err)
   );

   // Free-running clock.
   always #5 clock = ~clock;

   // Memory contents: low 32 bits hold the address itself, the rest is a hash.
   function automatic logic [DW-1:0] wordOf(input int a);
      logic [31:0] k;
      logic [31:0] h;
      k = a;
      h = k * 32'h9E37_79B1;
      return {h, ~h, h ^ 32'h5A5A_5A5A, h, h, h, h, k};
   endfunction

   // BRAM model with a registered read port.
   always @(posedge clock) begin
      if (ram_en) ramDout <= wordOf(int'(ram_addr));
   end

   task automatic compare(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checkCount++;
      if (act !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic failNow(input string name, input int act, input string need);
      checkCount++;
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %s", name, act, need);
   endtask

   function automatic vec_t mkVec(input logic cv, input int ca, input int cl, input logic rdy,
                                  input logic en, input int ra, input logic ov, input int wa,
                                  input logic lst, input logic crdy, input logic bsy, input logic er);
      vec_t v;
      v.cmdValid = cv;  v.cmdAddr = ca;  v.cmdLen = cl;  v.outReady = rdy;
      v.expRamEn = en;  v.expRamAddr = ra;  v.expOutValid = ov;  v.expWordAddr = wa;
      v.expLast = lst;  v.expCmdReady = crdy;  v.expBusy = bsy;  v.expErr = er;
      return v;
   endfunction

   task automatic applyStimulus(input vec_t v);
      cmd_valid = v.cmdValid;
      cmd_addr  = AW'(v.cmdAddr);
      cmd_len   = LW'(v.cmdLen);
      out_ready = v.outReady;
   endtask

   task automatic checkOutput(input vec_t v, input int idx);
      compare($sformatf("vec%0d_ram_en", idx), DW'(ram_en), DW'(v.expRamEn));
      compare($sformatf("vec%0d_ram_addr", idx), DW'(ram_addr), DW'(v.expRamAddr));
      compare($sformatf("vec%0d_out_valid", idx), DW'(out_valid), DW'(v.expOutValid));
      if (v.expOutValid) begin
         compare($sformatf("vec%0d_out_data", idx), out_data, wordOf(v.expWordAddr));
         compare($sformatf("vec%0d_out_last", idx), DW'(out_last), DW'(v.expLast));
      end
      compare($sformatf("vec%0d_cmd_ready", idx), DW'(cmd_ready), DW'(v.expCmdReady));
      compare($sformatf("vec%0d_busy", idx), DW'(busy), DW'(v.expBusy));
      compare($sformatf("vec%0d_err", idx), DW'(err), DW'(v.expErr));
   endtask

   // Reference model: every accepted command expands into its wrapped address
   // list; issues and delivered words must follow that list in order.
   task automatic checkStream();
      int a;
      bit l;
      compare("err_pulse", DW'(err), DW'(errExpectNow));
      errExpectNow = 1'b0;
      checkCount++;
      if (outstanding > 2) begin
         errorCount++;
         $display("[TB] FAIL occupancy_bound: got %0d, expected at most 2", outstanding);
      end
      if (prevStall) begin
         compare("hold_valid", DW'(out_valid), DW'(1'b1));
         compare("hold_data", out_data, prevData);
         compare("hold_last", DW'(out_last), DW'(prevLast));
      end
      if (ram_en) begin
         if (issueQ.size() == 0) failNow("spurious_issue", int'(ram_addr), "no read");
         else compare("issue_addr", DW'(ram_addr), DW'(issueQ.pop_front()));
         outstanding++;
      end
      if (out_valid && out_ready) begin
         if (wordQ.size() == 0) failNow("spurious_word", int'(out_data[31:0]), "no word");
         else begin
            a = wordQ.pop_front();
            l = lastQ.pop_front();
            compare("out_data", out_data, wordOf(a));
            compare("out_last", DW'(out_last), DW'(l));
         end
         outstanding--;
      end
      prevStall = out_valid && !out_ready;
      prevData  = out_data;
      prevLast  = out_last;
      if (cmd_valid && cmd_ready) begin
         handshakeSeen = 1'b1;
         if (int'(cmd_addr) < DEPTH) begin
            compare("accept_after_drain", DW'(wordQ.size() + issueQ.size()), DW'(0));
            for (int k = 0; k <= int'(cmd_len); k++) begin
               a = (int'(cmd_addr) + k) % DEPTH;
               issueQ.push_back(a);
               wordQ.push_back(a);
               lastQ.push_back(k == int'(cmd_len));
            end
         end else begin
            errExpectNow = 1'b1;
         end
      end
   endtask

   task automatic cycle();
      #1;
      if (monEn) checkStream();
      @(posedge clock);
      @(negedge clock);
   endtask

   // Mode 0 keeps out_ready high; mode 1 randomises it with 10-cycle low stretches.
   task automatic driveReady(input int mode);
      if (mode == 0) out_ready = 1'b1;
      else if (stretchLeft > 0) begin
         out_ready = 1'b0;
         stretchLeft--;
      end else if ($urandom_range(0, 11) == 0) begin
         out_ready   = 1'b0;
         stretchLeft = 9;
      end else out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic drainAll(input int mode);
      int t;
      t = 0;
      while ((wordQ.size() > 0 || busy) && t < 2000) begin
         driveReady(mode);
         cycle();
         t++;
      end
      if (t >= 2000) failNow("drain_timeout", wordQ.size(), "empty queue");
      out_ready = 1'b1;
      cycle();
   endtask

   task automatic runCommand(input int addr, input int len, input int mode);
      int t;
      cmd_valid = 1'b1;
      cmd_addr  = AW'(addr);
      cmd_len   = LW'(len);
      handshakeSeen = 1'b0;
      t = 0;
      while (!handshakeSeen && t < 200) begin
         driveReady(mode);
         cycle();
         t++;
      end
      cmd_valid = 1'b0;
      if (!handshakeSeen) failNow("accept_timeout", t, "handshake");
      drainAll(mode);
   endtask

   task automatic clearModel();
      issueQ.delete();
      wordQ.delete();
      lastQ.delete();
      outstanding  = 0;
      prevStall    = 1'b0;
      errExpectNow = 1'b0;
   endtask

   initial begin
      int n;
      // Basic read at 10..13, then single word at 5, then an out-of-range address.
      vecs.push_back(mkVec(1, 10, 3, 1,  0,  0,  0,  0, 0,  1, 0, 0));
      vecs.push_back(mkVec(0,  0, 0, 1,  1, 10,  0,  0, 0,  0, 1, 0));
      vecs.push_back(mkVec(0,  0, 0, 1,  1, 11,  0,  0, 0,  0, 1, 0));
      vecs.push_back(mkVec(0,  0, 0, 1,  1, 12,  1, 10, 0,  0, 1, 0));
      vecs.push_back(mkVec(0,  0, 0, 1,  1, 13,  1, 11, 0,  0, 1, 0));
      vecs.push_back(mkVec(0,  0, 0, 1,  0, 13,  1, 12, 0,  0, 1, 0));
      vecs.push_back(mkVec(0,  0, 0, 1,  0, 13,  1, 13, 1,  0, 1, 0));
      vecs.push_back(mkVec(0,  0, 0, 1,  0, 13,  0,  0, 0,  1, 0, 0));
      vecs.push_back(mkVec(1,  5, 0, 1,  0, 13,  0,  0, 0,  1, 0, 0));
      vecs.push_back(mkVec(0,  0, 0, 1,  1,  5,  0,  0, 0,  0, 1, 0));
      vecs.push_back(mkVec(0,  0, 0, 1,  0,  5,  0,  0, 0,  0, 1, 0));
      vecs.push_back(mkVec(0,  0, 0, 1,  0,  5,  1,  5, 1,  0, 1, 0));
      vecs.push_back(mkVec(1, DEPTH, 0, 1,  0,  5,  0,  0, 0,  1, 0, 0));
      vecs.push_back(mkVec(0,  0, 0, 1,  0,  5,  0,  0, 0,  1, 0, 1));
      vecs.push_back(mkVec(0,  0, 0, 1,  0,  5,  0,  0, 0,  1, 0, 0));

      // Reset state.
      repeat (3) @(negedge clock);
      #1;
      compare("rst_ram_en", DW'(ram_en), DW'(0));
      compare("rst_ram_addr", DW'(ram_addr), DW'(0));
      compare("rst_out_valid", DW'(out_valid), DW'(0));
      compare("rst_out_data", out_data, DW'(0));
      compare("rst_out_last", DW'(out_last), DW'(0));
      compare("rst_busy", DW'(busy), DW'(0));
      compare("rst_err", DW'(err), DW'(0));
      @(negedge clock);
      reset = 1'b0;
      #1;
      compare("rst_cmd_ready", DW'(cmd_ready), DW'(1));
      @(negedge clock);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         #1;
         checkOutput(vecs[i], i);
         @(posedge clock);
         @(negedge clock);
      end

      monEn = 1'b1;
      clearModel();

      // Backpressure starting with a 10-cycle stall.
      stretchLeft = 10;
      runCommand(0, 7, 1);

      // Wrap-around past the top of memory.
      runCommand(DEPTH - 2, 3, 0);

      // Back-to-back: the second command must wait exactly until IDLE returns.
      cmd_valid = 1'b1;
      cmd_addr  = AW'(50);
      cmd_len   = LW'(4);
      handshakeSeen = 1'b0;
      n = 0;
      while (!handshakeSeen && n < 200) begin
         driveReady(0);
         cycle();
         n++;
      end
      cmd_addr = AW'(2000);
      cmd_len  = LW'(2);
      handshakeSeen = 1'b0;
      n = 0;
      while (!handshakeSeen && n < 200) begin
         driveReady(0);
         cycle();
         n++;
      end
      cmd_valid = 1'b0;
      compare("b2b_accept_cycle", DW'(n), DW'(8));
      drainAll(0);

      // Reset during cycle 4 of a 16-word command with the consumer stalled.
      cmd_valid = 1'b1;
      cmd_addr  = AW'(300);
      cmd_len   = LW'(15);
      out_ready = 1'b0;
      cycle();
      cmd_valid = 1'b0;
      repeat (3) cycle();
      reset = 1'b1;
      #1;
      compare("midrst_ram_en", DW'(ram_en), DW'(0));
      compare("midrst_ram_addr", DW'(ram_addr), DW'(0));
      compare("midrst_out_valid", DW'(out_valid), DW'(0));
      compare("midrst_out_data", out_data, DW'(0));
      compare("midrst_out_last", DW'(out_last), DW'(0));
      compare("midrst_busy", DW'(busy), DW'(0));
      compare("midrst_cmd_ready", DW'(cmd_ready), DW'(1));
      @(negedge clock);
      reset = 1'b0;
      clearModel();
      runCommand(100, 1, 1);
      out_ready = 1'b1;
      repeat (4) cycle();

      // Random commands, some near the wrap point, plus one bad address.
      for (int r = 0; r < 8; r++) begin
         int addr;
         if (r % 3 == 0) addr = DEPTH - 1 - int'($urandom_range(0, 5));
         else addr = int'($urandom_range(0, DEPTH - 1));
         runCommand(addr, int'($urandom_range(0, 20)), 1);
      end
      runCommand(int'($urandom_range(DEPTH, 32767)), 3, 1);
      repeat (2) cycle();

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
